// File: rtl/vc_bus_pkg.sv
// rtl/vc_bus_pkg.sv - shared state, port and write-mask encodings for the external memory bus arbiter
package vc_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AHI  = 3'd1,
    S_ALO  = 3'd2,
    S_WR0  = 3'd3,
    S_WR1  = 3'd4,
    S_RD0  = 3'd5,
    S_RD1  = 3'd6,
    S_DONE = 3'd7
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam logic [1:0] WM_LO   = 2'b01;
  localparam logic [1:0] WM_HI   = 2'b10;
  localparam logic [1:0] WM_WORD = 2'b11;

endpackage

// File: rtl/vc_arb_pick.sv
// rtl/vc_arb_pick.sv - combinational two-way grant; VC_ARB_RR_EN selects round-robin over fixed priority
module vc_arb_pick (
  input  logic [1:0] i_req,
  input  logic       i_last_owner,
  output logic       o_valid,
  output logic       o_idx
);
  import vc_bus_pkg::*;

`ifdef VC_ARB_RR_EN
  always_comb begin
    o_valid = |i_req;
    o_idx   = PORT0;
    // A tie goes to whichever port was not served last.
    if (i_req == 2'b11) o_idx = ~i_last_owner;
    else if (i_req[1])  o_idx = PORT1;
  end
`else
  logic w_unused_last;
  assign w_unused_last = i_last_owner;

  always_comb begin
    o_valid = |i_req;
    o_idx   = PORT0;
    if (!i_req[0] && i_req[1]) o_idx = PORT1;
  end
`endif

endmodule

// File: rtl/vc_mem_arbiter.sv
// rtl/vc_mem_arbiter.sv - two-port arbiter/sequencer for the 8-bit multiplexed memory bus
// Grant policy comes from vc_arb_pick (VC_ARB_RR_EN: round-robin, else port 0 priority).
module vc_mem_arbiter #(
  parameter int RV = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [14:0]   p0_raddr,
  input  logic          p0_rreq,
  output logic [RV-1:0] p0_rdata,
  output logic          p0_rdone,
  input  logic [14:0]   p0_waddr,
  input  logic [1:0]    p0_wmask,
  input  logic [RV-1:0] p0_wdata,
  output logic          p0_wdone,
  input  logic [14:0]   p1_raddr,
  input  logic          p1_rreq,
  output logic [RV-1:0] p1_rdata,
  output logic          p1_rdone,
  input  logic [14:0]   p1_waddr,
  input  logic [1:0]    p1_wmask,
  input  logic [RV-1:0] p1_wdata,
  output logic          p1_wdone,
  output logic [7:0]    bus_out,
  input  logic [7:0]    bus_in,
  output logic          latch_hi,
  output logic          latch_lo,
  output logic          bus_write,
  output logic          bus_ind,
  output logic          owner
);
  import vc_bus_pkg::*;

  state_t        r_state, w_next;
  logic [14:0]   r_addr, w_addr;
  logic [1:0]    r_wmask, w_wmask;
  logic [RV-1:0] r_wdata, w_wdata, r_rdata;
  logic          r_is_wr, w_is_wr;
  logic          r_owner, w_owner;
  logic [7:0]    r_bus_out, w_bus_out;
  logic [3:0]    r_stb, w_stb;          // {latch_hi, latch_lo, bus_write, bus_ind}
  logic [1:0]    r_rdone, w_rdone;      // indexed by port
  logic [1:0]    r_wdone, w_wdone;
  logic [1:0]    w_req;
  logic          w_gnt_valid, w_gnt_idx;

  assign w_req = {p1_rreq | (|p1_wmask), p0_rreq | (|p0_wmask)};

  vc_arb_pick u_pick (
    .i_req        (w_req),
    .i_last_owner (r_owner),
    .o_valid      (w_gnt_valid),
    .o_idx        (w_gnt_idx)
  );

  always_comb begin
    w_next  = r_state;
    w_addr  = r_addr;
    w_wmask = r_wmask;
    w_wdata = r_wdata;
    w_is_wr = r_is_wr;
    w_owner = r_owner;
    case (r_state)
      S_IDLE: begin
        if (ena && w_gnt_valid) begin
          w_next  = S_AHI;
          w_owner = w_gnt_idx;
          // Within a port a pending write is served before a pending read.
          if (w_gnt_idx == PORT1) begin
            w_is_wr = |p1_wmask;
            w_wmask = p1_wmask;
            w_wdata = p1_wdata;
            w_addr  = (|p1_wmask) ? p1_waddr : p1_raddr;
          end else begin
            w_is_wr = |p0_wmask;
            w_wmask = p0_wmask;
            w_wdata = p0_wdata;
            w_addr  = (|p0_wmask) ? p0_waddr : p0_raddr;
          end
        end
      end
      S_AHI:   w_next = S_ALO;
      S_ALO:   w_next = r_is_wr ? S_WR0 : S_RD0;
      S_WR0:   w_next = (r_wmask == WM_WORD) ? S_WR1 : S_DONE;
      S_WR1:   w_next = S_DONE;
      S_RD0:   w_next = S_RD1;
      S_RD1:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they appear registered in that state.
  always_comb begin
    w_bus_out = r_bus_out;
    w_stb     = 4'b0000;
    w_rdone   = 2'b00;
    w_wdone   = 2'b00;
    case (w_next)
      S_AHI: begin
        w_bus_out = w_addr[14:7];
        w_stb     = 4'b1000;
      end
      S_ALO: begin
        w_bus_out = {w_addr[6:0], w_is_wr && (w_wmask == WM_HI)};
        w_stb     = 4'b0100;
      end
      S_WR0: begin
        w_bus_out = (w_wmask == WM_LO || w_wmask == WM_WORD) ? w_wdata[7:0] : w_wdata[15:8];
        w_stb     = 4'b0010;
      end
      S_WR1: begin
        w_bus_out = w_wdata[15:8];
        w_stb     = 4'b0011;
      end
      S_RD1:   w_stb = 4'b0001;
      S_DONE: begin
        if (w_is_wr) w_wdone[w_owner] = 1'b1;
        else         w_rdone[w_owner] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wmask   <= '0;
      r_wdata   <= '0;
      r_is_wr   <= 1'b0;
      r_owner   <= PORT0;
      r_bus_out <= '0;
      r_stb     <= '0;
      r_rdone   <= '0;
      r_wdone   <= '0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_next;
      r_addr    <= w_addr;
      r_wmask   <= w_wmask;
      r_wdata   <= w_wdata;
      r_is_wr   <= w_is_wr;
      r_owner   <= w_owner;
      r_bus_out <= w_bus_out;
      r_stb     <= w_stb;
      r_rdone   <= w_rdone;
      r_wdone   <= w_wdone;
      if (r_state == S_RD0) r_rdata[7:0]  <= bus_in;
      if (r_state == S_RD1) r_rdata[15:8] <= bus_in;
    end
  end

  assign bus_out   = r_bus_out;
  assign latch_hi  = r_stb[3];
  assign latch_lo  = r_stb[2];
  assign bus_write = r_stb[1];
  assign bus_ind   = r_stb[0];
  assign owner     = r_owner;
  assign p0_rdata  = r_rdata;
  assign p1_rdata  = r_rdata;
  assign p0_rdone  = r_rdone[0];
  assign p1_rdone  = r_rdone[1];
  assign p0_wdone  = r_wdone[0];
  assign p1_wdone  = r_wdone[1];

endmodule

// File: tb/tb_vc_mem_arbiter.sv
// tb/tb_vc_mem_arbiter.sv - self-checking bench for vc_mem_arbiter (honours VC_ARB_RR_EN)
module tb_vc_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, ena;
  logic [14:0] p0_raddr, p0_waddr, p1_raddr, p1_waddr;
  logic        p0_rreq, p1_rreq;
  logic [1:0]  p0_wmask, p1_wmask;
  logic [15:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
  logic        p0_rdone, p0_wdone, p1_rdone, p1_wdone;
  logic [7:0]  bus_out, bus_in;
  logic        latch_hi, latch_lo, bus_write, bus_ind, owner;

  always #5 clk = ~clk;

  vc_mem_arbiter #(.RV(16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .p0_raddr(p0_raddr), .p0_rreq(p0_rreq), .p0_rdata(p0_rdata), .p0_rdone(p0_rdone),
    .p0_waddr(p0_waddr), .p0_wmask(p0_wmask), .p0_wdata(p0_wdata), .p0_wdone(p0_wdone),
    .p1_raddr(p1_raddr), .p1_rreq(p1_rreq), .p1_rdata(p1_rdata), .p1_rdone(p1_rdone),
    .p1_waddr(p1_waddr), .p1_wmask(p1_wmask), .p1_wdata(p1_wdata), .p1_wdone(p1_wdone),
    .bus_out(bus_out), .bus_in(bus_in),
    .latch_hi(latch_hi), .latch_lo(latch_lo), .bus_write(bus_write), .bus_ind(bus_ind),
    .owner(owner)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One expected bus cycle; stb = {hi, lo, wr, ind}, smp 1/2 = capture low/high read byte, dn = {rdone, wdone}
  typedef struct packed {
    logic       busy;
    logic       drive;
    logic [7:0] bus;
    logic [3:0] stb;
    logic [1:0] smp;
    logic [1:0] dn;
  } rec_t;

  rec_t        cur;
  rec_t        q[$];
  logic        m_owner;
  logic [7:0]  m_bus;
  logic [15:0] m_rdata;
  logic        m_r0, m_r1, m_pick;

  function automatic rec_t mk(input logic drv, input logic [7:0] b, input logic [3:0] s,
                              input logic [1:0] sm, input logic [1:0] d);
    rec_t r;
    r.busy = 1'b1; r.drive = drv; r.bus = b; r.stb = s; r.smp = sm; r.dn = d;
    return r;
  endfunction

  task automatic build(input logic is_p1);
    logic [1:0]  wm;
    logic [14:0] a;
    logic [15:0] wd;
    logic        w;
    wm = is_p1 ? p1_wmask : p0_wmask;
    wd = is_p1 ? p1_wdata : p0_wdata;
    w  = (wm != 2'b00);
    a  = w ? (is_p1 ? p1_waddr : p0_waddr) : (is_p1 ? p1_raddr : p0_raddr);
    q.push_back(mk(1'b1, a[14:7], 4'b1000, 2'd0, 2'b00));
    q.push_back(mk(1'b1, {a[6:0], w && (wm == 2'b10)}, 4'b0100, 2'd0, 2'b00));
    if (w) begin
      q.push_back(mk(1'b1, wm[0] ? wd[7:0] : wd[15:8], 4'b0010, 2'd0, 2'b00));
      if (wm == 2'b11) q.push_back(mk(1'b1, wd[15:8], 4'b0011, 2'd0, 2'b00));
      q.push_back(mk(1'b0, 8'h00, 4'b0000, 2'd0, 2'b01));
    end else begin
      q.push_back(mk(1'b0, 8'h00, 4'b0000, 2'd1, 2'b00));
      q.push_back(mk(1'b0, 8'h00, 4'b0001, 2'd2, 2'b00));
      q.push_back(mk(1'b0, 8'h00, 4'b0000, 2'd0, 2'b10));
    end
  endtask

  // Transaction-level reference: a queue of expected cycles per granted request.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur = '0; q.delete(); m_owner = 1'b0; m_bus = 8'h00; m_rdata = 16'h0000;
    end else begin
      if (cur.smp == 2'd1) m_rdata[7:0]  = bus_in;
      if (cur.smp == 2'd2) m_rdata[15:8] = bus_in;
      if (q.size() > 0) cur = q.pop_front();
      else if (cur.busy || !ena) cur = '0;
      else begin
        m_r0 = p0_rreq || (p0_wmask != 2'b00);
        m_r1 = p1_rreq || (p1_wmask != 2'b00);
        if (!m_r0 && !m_r1) cur = '0;
        else begin
`ifdef VC_ARB_RR_EN
          m_pick = (m_r0 && m_r1) ? !m_owner : m_r1;
`else
          m_pick = !m_r0;
`endif
          m_owner = m_pick;
          build(m_pick);
          cur = q.pop_front();
        end
      end
      if (cur.drive) m_bus = cur.bus;
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      check("cycle",
            {15'd0, bus_out, latch_hi, latch_lo, bus_write, bus_ind, owner, p0_rdata, p1_rdata,
             p0_rdone, p0_wdone, p1_rdone, p1_wdone},
            {15'd0, m_bus, cur.stb, m_owner, m_rdata, m_rdata,
             cur.dn[1] & ~m_owner, cur.dn[0] & ~m_owner, cur.dn[1] & m_owner, cur.dn[0] & m_owner});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2000000");
    $fatal(1, "watchdog");
  end

  logic [3:0] order;
  int         got;
  bit         seen;

  initial begin
    rst_n = 1'b0; ena = 1'b1;
    p0_raddr = '0; p0_rreq = 1'b0; p0_waddr = '0; p0_wmask = '0; p0_wdata = '0;
    p1_raddr = '0; p1_rreq = 1'b0; p1_waddr = '0; p1_wmask = '0; p1_wdata = '0;
    bus_in = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_state", {15'd0, bus_out, latch_hi, latch_lo, bus_write, bus_ind, owner, p0_rdata,
                          p1_rdata, p0_rdone, p0_wdone, p1_rdone, p1_wdone}, 64'd0);
    rst_n = 1'b1; chk_en = 1'b1;
    @(negedge clk);

    // p0 word write 0x1234 <- 0xBEEF
    p0_waddr = 15'h091A; p0_wdata = 16'hBEEF; p0_wmask = 2'b11;
    @(negedge clk); check("w11_ahi", {bus_out, latch_hi, latch_lo, bus_write, bus_ind}, {8'h12, 4'b1000});
    @(negedge clk); check("w11_alo", {bus_out, latch_hi, latch_lo, bus_write, bus_ind}, {8'h34, 4'b0100});
    @(negedge clk); check("w11_wr0", {bus_out, latch_hi, latch_lo, bus_write, bus_ind}, {8'hEF, 4'b0010});
    @(negedge clk); check("w11_wr1", {bus_out, latch_hi, latch_lo, bus_write, bus_ind}, {8'hBE, 4'b0011});
    @(negedge clk); check("w11_done", {p0_wdone, p0_rdone, p1_wdone, p1_rdone}, 4'b1000);
    p0_wmask = 2'b00;
    @(negedge clk);

    // p1 high-byte write at 0x00A0 <- 0x5A00
    p1_waddr = 15'h0050; p1_wdata = 16'h5A00; p1_wmask = 2'b10;
    @(negedge clk); check("w10_ahi", {bus_out, latch_hi, latch_lo, bus_write, bus_ind}, {8'h00, 4'b1000});
    @(negedge clk); check("w10_alo", {bus_out, latch_hi, latch_lo, bus_write, bus_ind}, {8'hA1, 4'b0100});
    @(negedge clk); check("w10_wr0", {bus_out, latch_hi, latch_lo, bus_write, bus_ind}, {8'h5A, 4'b0010});
    @(negedge clk); check("w10_done", {p1_wdone, owner, latch_hi, latch_lo, bus_write, bus_ind}, 6'b110000);
    p1_wmask = 2'b00;
    @(negedge clk);

    // p0 read 0x4002, memory returns 0x11 then 0x22
    p0_raddr = 15'h2001; p0_rreq = 1'b1;
    @(negedge clk); check("rd_ahi", {bus_out, latch_hi, latch_lo, bus_write, bus_ind}, {8'h40, 4'b1000});
    @(negedge clk); check("rd_alo", {bus_out, latch_hi, latch_lo, bus_write, bus_ind}, {8'h02, 4'b0100});
    @(negedge clk); check("rd_rd0", {bus_out, latch_hi, latch_lo, bus_write, bus_ind}, {8'h02, 4'b0000});
    bus_in = 8'h11;
    @(negedge clk); check("rd_rd1", {bus_out, latch_hi, latch_lo, bus_write, bus_ind}, {8'h02, 4'b0001});
    bus_in = 8'h22;
    @(negedge clk); check("rd_done", {15'd0, p0_rdone, p0_rdata}, {15'd0, 1'b1, 16'h2211});
    p0_rreq = 1'b0;
    @(negedge clk);

    // Both ports read continuously; owner is 0 from the previous read
    p0_raddr = 15'h0100; p1_raddr = 15'h0200; p0_rreq = 1'b1; p1_rreq = 1'b1;
    got = 0; order = 4'b0000;
    for (int i = 0; i < 60 && got < 4; i++) begin
      @(negedge clk);
      if (p0_rdone || p1_rdone) begin
        order[got] = p1_rdone;
        got++;
        if (got == 4) begin p0_rreq = 1'b0; p1_rreq = 1'b0; end
      end
    end
    check("cont_count", 64'(got), 64'd4);
`ifdef VC_ARB_RR_EN
    check("cont_order", {60'd0, order}, {60'd0, 4'b0101});
`else
    check("cont_order", {60'd0, order}, {60'd0, 4'b0000});
`endif
    p0_rreq = 1'b0; p1_rreq = 1'b0;
    repeat (2) @(negedge clk);

    // Reset pulse during WR0 of a word write; the held request is served afterwards
    p0_waddr = 15'h091A; p0_wdata = 16'h1357; p0_wmask = 2'b11;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk); check("rst_mid", {bus_out, latch_hi, latch_lo, bus_write, bus_ind, p0_wdone, owner}, 14'd0);
    rst_n = 1'b1;
    @(negedge clk); check("rst_regrant", {latch_hi, bus_out}, {1'b1, 8'h12});
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (p0_wdone) seen = 1'b1;
    end
    check("rst_rewrite_done", {63'd0, seen}, 64'd1);
    p0_wmask = 2'b00;
    @(negedge clk);

    // ena low blocks grants; latch_hi follows one cycle after ena rises
    ena = 1'b0; p0_raddr = 15'h1111; p0_rreq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("ena_low_nogrant", {63'd0, latch_hi}, 64'd0);
    end
    ena = 1'b1;
    @(negedge clk); check("ena_rise_grant", {63'd0, latch_hi}, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (p0_rdone) seen = 1'b1;
    end
    check("ena_read_done", {63'd0, seen}, 64'd1);
    p0_rreq = 1'b0;
    @(negedge clk);

    // Randomized traffic on both ports, checked cycle by cycle against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (p0_wdone) p0_wmask = 2'b00;
      if (p0_rdone) p0_rreq  = 1'b0;
      if (p1_wdone) p1_wmask = 2'b00;
      if (p1_rdone) p1_rreq  = 1'b0;
      if (p0_wmask == 2'b00 && $urandom_range(0, 3) == 0) begin
        p0_wmask = 2'($urandom_range(1, 3)); p0_waddr = 15'($urandom); p0_wdata = 16'($urandom);
      end
      if (!p0_rreq && $urandom_range(0, 3) == 0) begin
        p0_rreq = 1'b1; p0_raddr = 15'($urandom);
      end
      if (p1_wmask == 2'b00 && $urandom_range(0, 3) == 0) begin
        p1_wmask = 2'($urandom_range(1, 3)); p1_waddr = 15'($urandom); p1_wdata = 16'($urandom);
      end
      if (!p1_rreq && $urandom_range(0, 3) == 0) begin
        p1_rreq = 1'b1; p1_raddr = 15'($urandom);
      end
      ena    = ($urandom_range(0, 9) != 0);
      bus_in = 8'($urandom);
    end
    p0_rreq = 1'b0; p1_rreq = 1'b0; p0_wmask = 2'b00; p1_wmask = 2'b00; ena = 1'b1;
    repeat (10) @(negedge clk);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
